// File: rtl/consmax_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : consmax_ctrl
// Brief    : ConSmax lane sequencer: LUT load, credit-based score feed and
//            result FIFO with row-last tagging.
// Revision : 1.0
// ============================================================================
module consmax_ctrl #(
    parameter int IDATA_BIT  = 8,
    parameter int ODATA_BIT  = 8,
    parameter int CDATA_BIT  = 8,
    parameter int LUT_DATA   = 16,
    parameter int LUT_ADDR   = 4,
    parameter int ROW_BIT    = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int PIPE_LAT   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CDATA_BIT-1:0]  cfg_shift,
    input  logic                  load_start,
    input  logic                  run_start,
    input  logic [ROW_BIT-1:0]    row_num,
    output logic                  busy,
    output logic                  done,
    output logic                  lut_loaded,
    input  logic                  lut_in_valid,
    output logic                  lut_in_ready,
    input  logic [LUT_DATA-1:0]   lut_in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IDATA_BIT-1:0]  in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ODATA_BIT-1:0]  out_data,
    output logic                  out_last,
    output logic [CDATA_BIT-1:0]  cm_shift,
    output logic [LUT_ADDR:0]     cm_lut_waddr,
    output logic                  cm_lut_wen,
    output logic [LUT_DATA-1:0]   cm_lut_wdata,
    output logic [IDATA_BIT-1:0]  cm_idata,
    output logic                  cm_idata_valid,
    input  logic [ODATA_BIT-1:0]  cm_odata,
    input  logic                  cm_odata_valid
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0]     c_depth = CW'(FIFO_DEPTH);
    localparam logic [LUT_ADDR:0] c_wlast = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t               r_state;
    logic [LUT_ADDR:0]    r_wcnt;
    logic                 r_load_fin;
    logic [ROW_BIT-1:0]   r_rows_left;
    logic [CW-1:0]        r_inflight;
    logic [CW-1:0]        r_cnt;
    logic                 r_ilast;
    logic [PIPE_LAT-1:0]  r_last_sr;
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [ODATA_BIT:0]   r_mem [FIFO_DEPTH];

    logic                 w_lut_hs;
    logic                 w_in_hs;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_dec;
    logic [CW-1:0]        w_cnt_nxt;
    logic [CW-1:0]        w_inflight_nxt;
    logic [ODATA_BIT:0]   w_head;

    // Credits cover both lane occupancy and FIFO fill, so the FIFO cannot overflow.
    assign in_ready     = (r_state == S_RUN) &&
                          (({1'b0, r_inflight} + {1'b0, r_cnt}) < {1'b0, c_depth});
    assign lut_in_ready = (r_state == S_LOAD);
    assign busy         = (r_state != S_IDLE);

    assign w_lut_hs       = lut_in_valid && lut_in_ready;
    assign w_in_hs        = in_valid && in_ready;
    assign w_push         = cm_odata_valid;
    assign w_pop          = out_valid && out_ready;
    assign w_dec          = cm_odata_valid && (r_inflight != '0);
    assign w_cnt_nxt      = r_cnt + CW'(w_push) - CW'(w_pop);
    assign w_inflight_nxt = r_inflight + CW'(w_in_hs) - CW'(w_dec);

    assign w_head    = r_mem[r_rd_ptr];
    assign out_valid = (r_cnt != '0);
    assign out_data  = out_valid ? w_head[ODATA_BIT-1:0] : '0;
    assign out_last  = out_valid ? w_head[ODATA_BIT] : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_wcnt         <= '0;
            r_load_fin     <= 1'b0;
            r_rows_left    <= '0;
            r_ilast        <= 1'b0;
            lut_loaded     <= 1'b0;
            done           <= 1'b0;
            cm_shift       <= '0;
            cm_lut_waddr   <= '0;
            cm_lut_wen     <= 1'b0;
            cm_lut_wdata   <= '0;
            cm_idata       <= '0;
            cm_idata_valid <= 1'b0;
        end else begin
            done           <= 1'b0;
            cm_lut_wen     <= 1'b0;
            cm_idata_valid <= 1'b0;
            r_ilast        <= 1'b0;
            if (r_load_fin) begin
                lut_loaded <= 1'b1;
                r_load_fin <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (load_start) begin
                        r_state    <= S_LOAD;
                        r_wcnt     <= '0;
                        lut_loaded <= 1'b0;
                        r_load_fin <= 1'b0;
                    end else if (run_start && lut_loaded && (row_num != '0)) begin
                        r_state     <= S_RUN;
                        cm_shift    <= cfg_shift;
                        r_rows_left <= row_num;
                    end
                end
                S_LOAD: begin
                    if (w_lut_hs) begin
                        cm_lut_wen   <= 1'b1;
                        cm_lut_waddr <= r_wcnt;
                        cm_lut_wdata <= lut_in_data;
                        r_wcnt       <= r_wcnt + 1'b1;
                        if (r_wcnt == c_wlast) begin
                            r_state    <= S_IDLE;
                            r_load_fin <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_in_hs) begin
                        cm_idata       <= in_data;
                        cm_idata_valid <= 1'b1;
                        r_ilast        <= in_last;
                        if (in_last) begin
                            r_rows_left <= r_rows_left - 1'b1;
                            if (r_rows_left == ROW_BIT'(1)) begin
                                r_state <= S_DRAIN;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    // Look ahead one cycle so done follows the final pop directly.
                    if ((w_inflight_nxt == '0) && (w_cnt_nxt == '0)) begin
                        r_state <= S_IDLE;
                        done    <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_inflight <= '0;
            r_last_sr  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_cnt      <= w_cnt_nxt;
            r_inflight <= w_inflight_nxt;
            // Fixed-latency lane: the last tag shifts every cycle alongside it.
            r_last_sr  <= (r_last_sr << 1) | PIPE_LAT'(r_ilast);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_last_sr[PIPE_LAT-1], cm_odata};
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && !w_pop && (r_cnt == c_depth)));

endmodule
`default_nettype wire
